// File: rtl/bram_master.sv
// Single-outstanding CPU load/store master for a synchronous single-port block RAM.
// Handles byte/half/word lanes, load extension, and rejects misaligned or out-of-range requests.
module bram_master #(
    parameter int RAM_ADDR_WIDTH = 13,
    parameter int RAM_BUS_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [31:0]               req_addr,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic [3:0]                mem_we,
    output logic [RAM_ADDR_WIDTH-1:0] mem_addr,
    output logic [RAM_BUS_WIDTH-1:0]  mem_data,
    input  logic [RAM_BUS_WIDTH-1:0]  mem_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                    state_reg;
    logic                      ready_reg;
    logic                      we_reg;
    logic                      unsigned_reg;
    logic [1:0]                size_reg;
    logic [1:0]                lane_reg;
    logic [3:0]                mem_we_reg;
    logic [RAM_ADDR_WIDTH-1:0] mem_addr_reg;
    logic [31:0]               mem_data_reg;
    logic                      rsp_valid_reg;
    logic                      rsp_err_reg;
    logic [31:0]               rsp_rdata_reg;

    logic        req_err;
    logic [3:0]  store_mask;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic [7:0]  out_byte [4];
    logic [15:0] out_half [2];

    assign req_ready = ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_data  = mem_data_reg;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_byte
        assign out_byte[gi] = mem_out[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
        assign out_half[gi] = mem_out[16*gi +: 16];
    end

    // Any address bit above the RAM window, misalignment or the reserved size rejects the request.
    always_comb begin
        req_err = (req_addr >> (RAM_ADDR_WIDTH + 2)) != 32'd0;
        case (req_size)
            2'b00:   ;
            2'b01:   if (req_addr[0]) req_err = 1'b1;
            2'b10:   if (req_addr[1:0] != 2'b00) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        store_mask = 4'b1111;
        store_data = req_wdata;
        case (req_size)
            2'b00: begin
                store_mask = 4'b0001 << req_addr[1:0];
                store_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                store_mask = req_addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        load_data = mem_out;
        case (size_reg)
            2'b00:   load_data = {{24{~unsigned_reg & out_byte[lane_reg][7]}}, out_byte[lane_reg]};
            2'b01:   load_data = {{16{~unsigned_reg & out_half[lane_reg[1]][15]}}, out_half[lane_reg[1]]};
            default: ;
        endcase
    end

    // ready is registered so it stays low throughout reset and rises one edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ready_reg     <= 1'b0;
            we_reg        <= 1'b0;
            unsigned_reg  <= 1'b0;
            size_reg      <= 2'b00;
            lane_reg      <= 2'b00;
            mem_we_reg    <= 4'b0000;
            mem_addr_reg  <= '0;
            mem_data_reg  <= 32'd0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= 32'd0;
        end else begin
            ready_reg     <= 1'b0;
            mem_we_reg    <= 4'b0000;
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b1;
                    if (req_valid && ready_reg) begin
                        ready_reg    <= 1'b0;
                        we_reg       <= req_we;
                        unsigned_reg <= req_unsigned;
                        size_reg     <= req_size;
                        lane_reg     <= req_addr[1:0];
                        if (req_err) begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                            rsp_rdata_reg <= 32'd0;
                        end else begin
                            state_reg    <= ISSUE;
                            mem_addr_reg <= req_addr[RAM_ADDR_WIDTH+1:2];
                            if (req_we) begin
                                mem_we_reg   <= store_mask;
                                mem_data_reg <= store_data;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (we_reg) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b0;
                        rsp_rdata_reg <= 32'd0;
                    end else begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    state_reg     <= RESP;
                    rsp_valid_reg <= 1'b1;
                    rsp_err_reg   <= 1'b0;
                    rsp_rdata_reg <= load_data;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule
